// File: rtl/bullet_hit_if.sv
// Bus between the bullet generator / player FSMs and the hit engine.
// The master drives the tick strobe, player box and bullet slots; the slave
// (the engine) returns HP, status flags and the hit/heal pulses.
interface bullet_hit_if #(
  parameter int NUM_BULLETS = 8,
  parameter int COORD_W     = 8,
  parameter int HP_W        = 8
);
  localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

  logic                          tick;
  logic [COORD_W-1:0]            player_x;
  logic [COORD_W-1:0]            player_y;
  logic [COORD_W-1:0]            player_size;
  logic                          is_move;
  logic [NUM_BULLETS*2*COORD_W-1:0] bullet_pos;
  logic [NUM_BULLETS*2*COORD_W-1:0] bullet_size;
  logic [NUM_BULLETS*2-1:0]      bullet_color;
  logic [NUM_BULLETS-1:0]        bullet_valid;
  logic [HP_W-1:0]               hp;
  logic                          dead;
  logic                          hit_pulse;
  logic                          heal_pulse;
  logic [IDX_W-1:0]              hit_index;
  logic                          invuln;
  logic                          busy;

  modport master (
    output tick, player_x, player_y, player_size, is_move,
           bullet_pos, bullet_size, bullet_color, bullet_valid,
    input  hp, dead, hit_pulse, heal_pulse, hit_index, invuln, busy
  );

  modport slave (
    input  tick, player_x, player_y, player_size, is_move,
           bullet_pos, bullet_size, bullet_color, bullet_valid,
    output hp, dead, hit_pulse, heal_pulse, hit_index, invuln, busy
  );
endinterface

// File: rtl/bullet_hit_engine.sv
// Collision and damage engine for the battle screen.
//
//   state | meaning
//   IDLE  | waiting for a game tick (a pending start is held in start_q)
//   SCAN  | one bullet slot evaluated per clock, idx_q = slot under test
//   APPLY | single cycle: commit damage / heal / death and raise pulses
//
// A tick accepted at edge t latches the player box and decrements the
// invulnerability counter; the FSM enters SCAN one edge later, so slot k is
// evaluated in the cycle after edge t+1+k and results land at edge t+N+2.
module bullet_hit_engine #(
  parameter int NUM_BULLETS = 8,
  parameter int COORD_W     = 8,
  parameter int HP_W        = 8,
  parameter int MAX_HP      = 100,
  parameter int DMG         = 5,
  parameter int HEAL        = 3,
  parameter int IFRAMES     = 10
) (
  input  logic        clk,
  input  logic        reset,
  bullet_hit_if.slave bus
);

  localparam int IDX_W  = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int INV_W  = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
  localparam int SLOT_W = 2 * COORD_W;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BULLETS - 1);
  localparam logic [HP_W-1:0]  MAX_HP_V   = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0]  DMG_V      = HP_W'(DMG);
  localparam logic [HP_W:0]    MAX_HP_EXT = (HP_W + 1)'(MAX_HP);
  localparam logic [HP_W:0]    HEAL_EXT   = (HP_W + 1)'(HEAL);
  localparam logic [INV_W-1:0] IFRAMES_V  = INV_W'(IFRAMES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d, ps_q, ps_d;
  logic               move_q, move_d;
  logic               dmg_found_q, dmg_found_d;
  logic [IDX_W-1:0]   dmg_idx_q, dmg_idx_d;
  logic               heal_found_q, heal_found_d;
  logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic               dead_q, dead_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               heal_pulse_q, heal_pulse_d;
  logic [IDX_W-1:0]   hit_index_q, hit_index_d;

  logic               accept_tick;
  logic [SLOT_W-1:0]  slot_pos, slot_size;
  logic [1:0]         slot_color;
  logic               slot_valid;
  logic [COORD_W-1:0] bx, by, bw, bh;
  logic [COORD_W:0]   bx_end, by_end, px_end, py_end;
  logic               collide, hit_dmg, hit_heal;
  logic               apply_dmg;
  logic [HP_W-1:0]    h1;
  logic [HP_W:0]      heal_sum;

  // Ticks are taken only from a quiet IDLE; anything else is dropped.
  assign accept_tick = (state_q == S_IDLE) && !start_q && bus.tick && !dead_q;

  // Current slot extraction and box-overlap test, sums one bit wider than coords.
  always_comb begin
    slot_pos   = bus.bullet_pos[idx_q*SLOT_W +: SLOT_W];
    slot_size  = bus.bullet_size[idx_q*SLOT_W +: SLOT_W];
    slot_color = bus.bullet_color[idx_q*2 +: 2];
    slot_valid = bus.bullet_valid[idx_q];
    bx = slot_pos[SLOT_W-1:COORD_W];
    by = slot_pos[COORD_W-1:0];
    bw = slot_size[SLOT_W-1:COORD_W];
    bh = slot_size[COORD_W-1:0];
    bx_end = {1'b0, bx} + {1'b0, bw};
    by_end = {1'b0, by} + {1'b0, bh};
    px_end = {1'b0, px_q} + {1'b0, ps_q};
    py_end = {1'b0, py_q} + {1'b0, ps_q};
    collide = slot_valid && (bw != '0) && (bh != '0) &&
              ({1'b0, px_q} < bx_end) && ({1'b0, bx} < px_end) &&
              ({1'b0, py_q} < by_end) && ({1'b0, by} < py_end);
    hit_dmg  = 1'b0;
    hit_heal = 1'b0;
    case (slot_color)
      2'd0:    hit_dmg  = collide;
      2'd1:    hit_dmg  = collide && move_q;
      2'd2:    hit_dmg  = collide && !move_q;
      default: hit_heal = collide;
    endcase
  end

  // Damage / heal arithmetic used during APPLY.
  always_comb begin
    apply_dmg = dmg_found_q && (inv_cnt_q == '0);
    h1 = hp_q;
    if (apply_dmg) begin
      h1 = (hp_q > DMG_V) ? (hp_q - DMG_V) : '0;
    end
    heal_sum = {1'b0, h1} + HEAL_EXT;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_SCAN;
        end else if (accept_tick) begin
          start_d = 1'b1;
        end
      end
      S_SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_APPLY;
        end
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: tick latch, scan accumulation, HP commit.
  always_comb begin
    idx_d        = idx_q;
    px_d         = px_q;
    py_d         = py_q;
    ps_d         = ps_q;
    move_d       = move_q;
    dmg_found_d  = dmg_found_q;
    dmg_idx_d    = dmg_idx_q;
    heal_found_d = heal_found_q;
    inv_cnt_d    = inv_cnt_q;
    hp_d         = hp_q;
    dead_d       = dead_q;
    hit_pulse_d  = 1'b0;
    heal_pulse_d = 1'b0;
    hit_index_d  = hit_index_q;

    if (accept_tick) begin
      px_d         = bus.player_x;
      py_d         = bus.player_y;
      ps_d         = bus.player_size;
      move_d       = bus.is_move;
      dmg_found_d  = 1'b0;
      heal_found_d = 1'b0;
      idx_d        = '0;
      if (inv_cnt_q != '0) begin
        inv_cnt_d = inv_cnt_q - INV_W'(1);
      end
    end

    if (state_q == S_SCAN) begin
      if (hit_dmg && !dmg_found_q) begin
        dmg_found_d = 1'b1;
        dmg_idx_d   = idx_q;
      end
      if (hit_heal) begin
        heal_found_d = 1'b1;
      end
      if (idx_q != LAST_IDX) begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (state_q == S_APPLY) begin
      if (h1 == '0) begin
        hp_d   = '0;
        dead_d = 1'b1;
      end else if (heal_found_q) begin
        hp_d         = (heal_sum > MAX_HP_EXT) ? MAX_HP_V : heal_sum[HP_W-1:0];
        heal_pulse_d = 1'b1;
      end else begin
        hp_d = h1;
      end
      if (apply_dmg) begin
        inv_cnt_d   = IFRAMES_V;
        hit_index_d = dmg_idx_q;
        hit_pulse_d = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
    end
  end

  // Datapath registers; reset restores full HP and clears any scan in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      ps_q         <= '0;
      move_q       <= 1'b0;
      dmg_found_q  <= 1'b0;
      dmg_idx_q    <= '0;
      heal_found_q <= 1'b0;
      inv_cnt_q    <= '0;
      hp_q         <= MAX_HP_V;
      dead_q       <= 1'b0;
      hit_pulse_q  <= 1'b0;
      heal_pulse_q <= 1'b0;
      hit_index_q  <= '0;
    end else begin
      idx_q        <= idx_d;
      px_q         <= px_d;
      py_q         <= py_d;
      ps_q         <= ps_d;
      move_q       <= move_d;
      dmg_found_q  <= dmg_found_d;
      dmg_idx_q    <= dmg_idx_d;
      heal_found_q <= heal_found_d;
      inv_cnt_q    <= inv_cnt_d;
      hp_q         <= hp_d;
      dead_q       <= dead_d;
      hit_pulse_q  <= hit_pulse_d;
      heal_pulse_q <= heal_pulse_d;
      hit_index_q  <= hit_index_d;
    end
  end

  assign bus.hp         = hp_q;
  assign bus.dead       = dead_q;
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.heal_pulse = heal_pulse_q;
  assign bus.hit_index  = hit_index_q;
  assign bus.invuln     = (inv_cnt_q != '0);
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: doc/bullet_hit_engine.md
# bullet_hit_engine

Parametrised collision-and-damage engine for the battle screen. It replaces the single-bullet collision check and damage calculator pair with one sequential unit. On each game tick it scans NUM_BULLETS bullet slots against the player box, one slot per clock, then applies colour-dependent damage or healing to player HP with an invulnerability window. It sits between the bullet generator and the player/machine FSMs and feeds HP to the renderer.

## Interface
- NUM_BULLETS, 8, number of bullet slots scanned per tick (>=1)
- COORD_W, 8, width of every coordinate and size field
- HP_W, 8, HP register width
- MAX_HP, 100, reset and ceiling value of HP
- DMG, 5, HP removed per damaging hit
- HEAL, 3, HP restored per green-bullet contact
- IFRAMES, 10, ticks of invulnerability after a damaging hit
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-clk game-tick strobe (20 Hz domain pulse)
- player_x, player_y  in  COORD_W each  player box top-left
- player_size  in  COORD_W  player box width = height
- is_move  in  1  player moved this tick
- bullet_pos  in  NUM_BULLETS*2*COORD_W  slot i = {x,y} at bits [i*2*COORD_W +: 2*COORD_W], x in the upper half
- bullet_size  in  NUM_BULLETS*2*COORD_W  slot i = {w,h}, same packing
- bullet_color  in  NUM_BULLETS*2  0 white, 1 blue, 2 orange, 3 green
- bullet_valid  in  NUM_BULLETS  slot active
- hp  out  HP_W  current HP
- dead  out  1  sticky, HP reached 0
- hit_pulse  out  1  one clk: damage applied
- heal_pulse  out  1  one clk: heal applied
- hit_index  out  clog2(NUM_BULLETS) (min 1)  slot of last applied damage
- invuln  out  1  invulnerability counter nonzero
- busy  out  1  scan in progress

## Operation
- FSM states: IDLE, SCAN, APPLY.
- IDLE, tick=1, dead=0: latch player_x/y/size and is_move, decrement the invuln counter if nonzero, clear the dmg/heal found flags, idx=0, go to SCAN. A tick while dead=1 is ignored.
- SCAN: evaluate slot idx. Collide = valid & w!=0 & h!=0 & px < bx+w & bx < px+ps & py < by+h & by < py+ps. Sums are COORD_W+1 bits, so nothing wraps.
- Damaging contact: white always; blue only if is_move=1; orange only if is_move=0. The first (lowest index) damaging slot is recorded as dmg_found and dmg_idx. Any green contact sets heal_found.
- idx increments each cycle. After idx=NUM_BULLETS-1, go to APPLY.
- Bullet inputs are sampled live during SCAN. Upstream holds them stable from tick until busy falls.
- APPLY (one cycle), then IDLE:
  - apply_dmg = dmg_found & invuln counter==0.
  - h1 = apply_dmg ? (hp>DMG ? hp-DMG : 0) : hp.
  - If h1==0: hp=0, dead=1, and heal is suppressed.
  - Otherwise, if heal_found: hp = min(h1+HEAL, MAX_HP), computed at HP_W+1 bits.
  - If apply_dmg: invuln counter=IFRAMES, hit_index=dmg_idx, hit_pulse=1.
  - heal_pulse=1 only if heal_found and the heal was actually applied.
- Healing is allowed during invulnerability. Damage during invulnerability is discarded and no pulse is raised.
- A tick arriving in SCAN or APPLY is dropped, not queued.

## Timing
- Reset values: hp=MAX_HP, dead=0, hit_pulse=0, heal_pulse=0, hit_index=0, invuln=0, busy=0, invuln counter=0, state IDLE.
- Reset mid-SCAN/APPLY aborts the scan. No HP change occurs.
- Tick sampled at edge t:
  - busy=1 from t+1 through t+NUM_BULLETS+1.
  - Slot k is evaluated in cycle t+1+k.
  - hp, dead, pulses, hit_index and invuln update at edge t+NUM_BULLETS+2.
- Pulses are exactly one clk wide.
- invuln reflects the counter register directly. The counter decrements at the tick edge, so IFRAMES=10 blocks damage for the next 9 scans.
- Minimum tick spacing for no drops: NUM_BULLETS+2 clks.

## Test plan
- Reset, then player at (50,50) size 10, slot 3 white at (55,55) 4x4, tick -> hit_pulse at t+10 (N=8), hp 100->95, hit_index=3, invuln=1.
- Same overlap on the next 9 ticks -> no hit_pulse, hp stays 95. 10th subsequent tick -> hp=90.
- Blue overlapping with is_move=0 -> no damage. With is_move=1 -> damage. Orange gives the inverse.
- White on slots 2 and 6 plus green on slot 0, hp=98 -> hp = min(93+3,100) = 96, hit_index=2, both pulses high.
- hp=4, white hit -> hp=0, dead=1, heal suppressed. Later ticks leave busy=0 and hp=0 until reset.
- Edge contact (bx = px+ps) and size 0 -> no collision. Box at x=250, w=10 -> no wrap false hit. Reset asserted mid-scan -> hp=MAX_HP, busy=0 next clk.
